mc_control: RTL and testbench

Multicycle main controller for the MIPS core. A Moore/Mealy FSM sequences a shared-memory multicycle datapath (PC, IR, register file, ALU, ALUOut) through fetch, decode, execute, memory and writeback. It sits beside the datapath in `cpu`, replacing the single-cycle `control` decode. It stalls on a memory ready handshake and traps on unsupported opcodes.

---
 rtl/mc_pkg.sv | 75 +++++++
 rtl/mc_outdec.sv | 92 +++++++++
 rtl/mc_control.sv | 87 ++++++++
 tb/tb_mc_control.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mc_pkg.sv
// Shared definitions for the multicycle MIPS main controller:
// state encoding, opcodes, datapath select encodings and the control word.
package mc_pkg;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_ALUWB  = 4'd7,
        S_BRANCH = 4'd8,
        S_ADDIEX = 4'd9,
        S_ADDIWB = 4'd10,
        S_JUMP   = 4'd11,
        S_TRAP   = 4'd12
    } state_e;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [1:0] SRCB_REG  = 2'b00;
    localparam logic [1:0] SRCB_FOUR = 2'b01;
    localparam logic [1:0] SRCB_IMM  = 2'b10;
    localparam logic [1:0] SRCB_IMM2 = 2'b11;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    typedef struct packed {
        logic       pc_write;
        logic       branch;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       mem_to_reg;
        logic       reg_dst;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] pc_src;
        logic       inst_done;
        logic       illegal;
    } ctrl_t;

    localparam int CTRL_W = $bits(ctrl_t);

    function automatic state_e decode_next(input logic [5:0] op);
        state_e s;
        s = S_TRAP;
        case (op)
            OP_LW, OP_SW: s = S_MEMADR;
            OP_RTYPE:     s = S_EXEC;
            OP_BEQ:       s = S_BRANCH;
            OP_ADDI:      s = S_ADDIEX;
            OP_J:         s = S_JUMP;
            default:      s = S_TRAP;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/mc_outdec.sv
// State to control-word decoder; FETCH and MEMWR carry Mealy terms
// that depend on the memory ready handshake.
module mc_outdec
    import mc_pkg::*;
(
    input  logic [3:0]        state_i,
    input  logic              mem_ready_i,
    input  logic              rst_ni,
    output logic [CTRL_W-1:0] ctrl_o
);

    state_e st;
    ctrl_t  c;

    assign st     = state_e'(state_i);
    assign ctrl_o = c;

    always_comb begin
        c = '0;
        unique case (st)
            S_FETCH: begin
                c.mem_read  = 1'b1;
                c.alu_src_b = SRCB_FOUR;
                c.alu_op    = ALUOP_ADD;
                c.pc_src    = PCSRC_ALU;
                // IR/PC must not load while the core is held in reset
                c.ir_write  = mem_ready_i & rst_ni;
                c.pc_write  = mem_ready_i & rst_ni;
            end
            S_DECODE: begin
                c.alu_src_b = SRCB_IMM2;
                c.alu_op    = ALUOP_ADD;
            end
            S_MEMADR: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = SRCB_IMM;
                c.alu_op    = ALUOP_ADD;
            end
            S_MEMRD: begin
                c.iord     = 1'b1;
                c.mem_read = 1'b1;
            end
            S_MEMWB: begin
                c.reg_write  = 1'b1;
                c.mem_to_reg = 1'b1;
                c.inst_done  = 1'b1;
            end
            S_MEMWR: begin
                c.iord      = 1'b1;
                c.mem_write = 1'b1;
                c.inst_done = mem_ready_i;
            end
            S_EXEC: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = SRCB_REG;
                c.alu_op    = ALUOP_FUNCT;
            end
            S_ALUWB: begin
                c.reg_dst   = 1'b1;
                c.reg_write = 1'b1;
                c.inst_done = 1'b1;
            end
            S_BRANCH: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = SRCB_REG;
                c.alu_op    = ALUOP_SUB;
                c.pc_src    = PCSRC_ALUOUT;
                c.branch    = 1'b1;
                c.inst_done = 1'b1;
            end
            S_ADDIEX: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = SRCB_IMM;
                c.alu_op    = ALUOP_ADD;
            end
            S_ADDIWB: begin
                c.reg_write = 1'b1;
                c.inst_done = 1'b1;
            end
            S_JUMP: begin
                c.pc_src    = PCSRC_JUMP;
                c.pc_write  = 1'b1;
                c.inst_done = 1'b1;
            end
            S_TRAP: begin
                c.illegal = 1'b1;
            end
            default: c = '0;
        endcase
    end

endmodule

// File: rtl/mc_control.sv
// Multicycle main controller FSM: state register, latched opcode and
// next-state logic; control outputs come from mc_outdec.
module mc_control
    import mc_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] opcode,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic       branch,
    output logic       iord,
    output logic       mem_read,
    output logic       mem_write,
    output logic       ir_write,
    output logic       mem_to_reg,
    output logic       reg_dst,
    output logic       reg_write,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic [1:0] pc_src,
    output logic       inst_done,
    output logic       illegal
);

    state_e            state_q, state_d;
    logic [5:0]        op_q, op_d;
    logic [CTRL_W-1:0] ctrl_w;
    ctrl_t             cw;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_FETCH;
            op_q    <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
        end
    end

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        unique case (state_q)
            S_FETCH:  if (mem_ready) state_d = S_DECODE;
            S_DECODE: begin
                op_d    = opcode;
                state_d = decode_next(opcode);
            end
            S_MEMADR: state_d = (op_q == OP_LW) ? S_MEMRD : S_MEMWR;
            S_MEMRD:  if (mem_ready) state_d = S_MEMWB;
            S_MEMWR:  if (mem_ready) state_d = S_FETCH;
            S_EXEC:   state_d = S_ALUWB;
            S_ADDIEX: state_d = S_ADDIWB;
            S_MEMWB, S_ALUWB, S_BRANCH,
            S_ADDIWB, S_JUMP: state_d = S_FETCH;
            S_TRAP:   state_d = S_TRAP;
            default:  state_d = S_FETCH;
        endcase
    end

    mc_outdec u_outdec (
        .state_i     (state_q),
        .mem_ready_i (mem_ready),
        .rst_ni      (rst),
        .ctrl_o      (ctrl_w)
    );

    assign cw         = ctrl_t'(ctrl_w);
    assign pc_write   = cw.pc_write;
    assign branch     = cw.branch;
    assign iord       = cw.iord;
    assign mem_read   = cw.mem_read;
    assign mem_write  = cw.mem_write;
    assign ir_write   = cw.ir_write;
    assign mem_to_reg = cw.mem_to_reg;
    assign reg_dst    = cw.reg_dst;
    assign reg_write  = cw.reg_write;
    assign alu_src_a  = cw.alu_src_a;
    assign alu_src_b  = cw.alu_src_b;
    assign alu_op     = cw.alu_op;
    assign pc_src     = cw.pc_src;
    assign inst_done  = cw.inst_done;
    assign illegal    = cw.illegal;

endmodule

// File: tb/tb_mc_control.sv
// Bench for mc_control: instruction-step reference model checked every
// cycle, directed scenarios with literal expectations, random traffic.
module tb_mc_control;

    typedef struct packed {
        logic       pc_write;
        logic       branch;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       mem_to_reg;
        logic       reg_dst;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] pc_src;
        logic       inst_done;
        logic       illegal;
    } ow_t;

    localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, RT = 6'b000000;
    localparam logic [5:0] BEQ = 6'b000100, ADDI = 6'b001000, JMP = 6'b000010;

    logic       clk, rst, mem_ready;
    logic [5:0] opcode;
    logic       pc_write, branch, iord, mem_read, mem_write, ir_write;
    logic       mem_to_reg, reg_dst, reg_write, alu_src_a, inst_done, illegal;
    logic [1:0] alu_src_b, alu_op, pc_src;
    ow_t        got;

    mc_control dut (
        .clk(clk), .rst(rst), .opcode(opcode), .mem_ready(mem_ready),
        .pc_write(pc_write), .branch(branch), .iord(iord),
        .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
        .mem_to_reg(mem_to_reg), .reg_dst(reg_dst), .reg_write(reg_write),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
        .pc_src(pc_src), .inst_done(inst_done), .illegal(illegal)
    );

    assign got = {pc_write, branch, iord, mem_read, mem_write, ir_write,
                  mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b,
                  alu_op, pc_src, inst_done, illegal};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: step index within the current instruction
    int         m_step;
    logic [5:0] m_op;
    bit         m_trap;
    int         n_cmp, n_fail;
    bit         chk_en;

    function automatic bit legal(input logic [5:0] op);
        return op inside {LW, SW, RT, BEQ, ADDI, JMP};
    endfunction

    function automatic int ilen(input logic [5:0] op);
        if (op == LW) return 5;
        if (op == BEQ || op == JMP) return 3;
        return 4;
    endfunction

    function automatic bit waits(input logic [5:0] op, input int step);
        return step == 3 && (op == LW || op == SW);
    endfunction

    function automatic ow_t model_out(input int step, input logic [5:0] op,
                                      input bit trap, input logic rdy,
                                      input logic rstn);
        ow_t o;
        o = '0;
        if (trap) begin
            o.illegal = 1'b1;
            return o;
        end
        if (step == 0) begin
            o.mem_read  = 1'b1;
            o.alu_src_b = 2'b01;
            o.ir_write  = rdy & rstn;
            o.pc_write  = rdy & rstn;
        end else if (step == 1) begin
            o.alu_src_b = 2'b11;
        end else if (op == LW || op == SW) begin
            if (step == 2) begin
                o.alu_src_a = 1'b1;
                o.alu_src_b = 2'b10;
            end else if (step == 3) begin
                o.iord      = 1'b1;
                o.mem_read  = (op == LW);
                o.mem_write = (op == SW);
                o.inst_done = (op == SW) & rdy;
            end else begin
                o.reg_write  = 1'b1;
                o.mem_to_reg = 1'b1;
                o.inst_done  = 1'b1;
            end
        end else if (op == RT) begin
            if (step == 2) begin
                o.alu_src_a = 1'b1;
                o.alu_op    = 2'b10;
            end else begin
                o.reg_dst   = 1'b1;
                o.reg_write = 1'b1;
                o.inst_done = 1'b1;
            end
        end else if (op == ADDI) begin
            if (step == 2) begin
                o.alu_src_a = 1'b1;
                o.alu_src_b = 2'b10;
            end else begin
                o.reg_write = 1'b1;
                o.inst_done = 1'b1;
            end
        end else if (op == BEQ) begin
            o.alu_src_a = 1'b1;
            o.alu_op    = 2'b01;
            o.pc_src    = 2'b01;
            o.branch    = 1'b1;
            o.inst_done = 1'b1;
        end else begin
            o.pc_src    = 2'b10;
            o.pc_write  = 1'b1;
            o.inst_done = 1'b1;
        end
        return o;
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_step <= 0;
            m_op   <= '0;
            m_trap <= 1'b0;
        end else if (!m_trap) begin
            if (m_step == 0) begin
                if (mem_ready) m_step <= 1;
            end else if (m_step == 1) begin
                m_op <= opcode;
                if (legal(opcode)) m_step <= 2;
                else m_trap <= 1'b1;
            end else if (!(waits(m_op, m_step) && !mem_ready)) begin
                m_step <= (m_step == ilen(m_op) - 1) ? 0 : m_step + 1;
            end
        end
    end

    always @(negedge clk) begin
        ow_t e;
        if (chk_en) begin
            e = model_out(m_step, m_op, m_trap, mem_ready, rst);
            n_cmp++;
            if (got !== e) begin
                n_fail++;
                $display("FAIL percycle t=%0t step=%0d op=%b got=%h exp=%h",
                         $time, m_step, m_op, got, e);
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] g,
                       input logic [31:0] e);
        n_cmp++;
        if (g !== e) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", nm, g, e);
        end
    endtask

    ow_t cap [1:64];
    int  ir_cnt, rw_cnt, strobe_cnt;

    // Runs one instruction from FETCH; returns retiring cycle or -1
    task automatic run_op(input logic [5:0] op, input int fwait,
                          input int mwait, input int maxc,
                          output int done_cyc);
        int fcnt, mcnt;
        fcnt = 0;
        mcnt = 0;
        done_cyc = -1;
        ir_cnt = 0;
        rw_cnt = 0;
        strobe_cnt = 0;
        for (int c = 1; c <= maxc; c++) begin
            opcode = op;
            if (m_step == 0 && !m_trap) begin
                mem_ready = (fcnt >= fwait);
                fcnt++;
            end else if (waits(m_op, m_step) && !m_trap) begin
                mem_ready = (mcnt >= mwait);
                mcnt++;
            end else begin
                mem_ready = 1'($urandom_range(0, 1));
            end
            @(negedge clk);
            cap[c] = got;
            if (got.ir_write) ir_cnt++;
            if (got.reg_write) rw_cnt++;
            if (c > 2 && (got.pc_write | got.branch | got.ir_write |
                          got.mem_read | got.mem_write | got.reg_write |
                          got.inst_done))
                strobe_cnt++;
            if (got.inst_done) done_cyc = c;
            @(posedge clk);
            #1;
            if (done_cyc > 0) break;
        end
    endtask

    ow_t fetch_rst;

    task automatic do_reset(input bit check);
        rst = 1'b0;
        #1;
        if (check) chk("reset_fetch_outputs", 32'(got), 32'(fetch_rst));
        @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    function automatic logic [5:0] pick_op();
        logic [5:0] ops [6];
        ops = '{RT, LW, SW, BEQ, ADDI, JMP};
        if ($urandom_range(0, 99) < 3) return 6'($urandom_range(0, 63));
        return ops[$urandom_range(0, 5)];
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        int c, trap_cycles;
        rst = 1'b0;
        opcode = 6'b0;
        mem_ready = 1'b1;
        n_cmp = 0;
        n_fail = 0;
        fetch_rst = '0;
        fetch_rst.mem_read = 1'b1;
        fetch_rst.alu_src_b = 2'b01;
        chk_en = 1'b1;
        @(posedge clk);
        #1;
        chk("reset_state", 32'(got), 32'(fetch_rst));
        @(posedge clk);
        #1;
        rst = 1'b1;

        run_op(RT, 0, 0, 10, c);
        chk("rtype_cycles", 32'(c), 32'd4);
        chk("rtype_exec_aluop", 32'(cap[3].alu_op), 32'd2);
        chk("rtype_wb_dst_wr", 32'({cap[4].reg_dst, cap[4].reg_write}), 32'd3);

        run_op(LW, 2, 3, 20, c);
        chk("lw_stall_cycles", 32'(c), 32'd10);
        chk("lw_irwrite_once", 32'(ir_cnt), 32'd1);
        chk("lw_memtoreg", 32'(cap[10].mem_to_reg), 32'd1);

        run_op(SW, 0, 0, 10, c);
        chk("sw_cycles", 32'(c), 32'd4);
        chk("sw_c4_wr_iord_done",
            32'({cap[4].mem_write, cap[4].iord, cap[4].inst_done}), 32'd7);
        chk("sw_no_regwrite", 32'(rw_cnt), 32'd0);

        run_op(BEQ, 0, 0, 10, c);
        chk("beq_cycles", 32'(c), 32'd3);
        chk("beq_c3_br_op_pcsrc",
            32'({cap[3].branch, cap[3].alu_op, cap[3].pc_src}), 32'b10101);

        run_op(JMP, 0, 0, 10, c);
        chk("j_cycles", 32'(c), 32'd3);
        chk("j_c3_pcw_pcsrc", 32'({cap[3].pc_write, cap[3].pc_src}), 32'b110);

        run_op(ADDI, 1, 0, 10, c);
        chk("addi_fetchwait_cycles", 32'(c), 32'd5);

        run_op(6'b111111, 0, 0, 22, c);
        chk("trap_no_done", 32'(c), 32'hffff_ffff);
        chk("trap_illegal", 32'(got.illegal), 32'd1);
        chk("trap_strobes_zero", 32'(strobe_cnt), 32'd0);
        mem_ready = 1'b1;
        do_reset(1'b1);
        chk("trap_cleared", 32'(got.illegal), 32'd0);

        run_op(LW, 0, 100, 5, c);
        chk("memrd_abort_no_done", 32'(c), 32'hffff_ffff);
        mem_ready = 1'b1;
        do_reset(1'b1);
        run_op(ADDI, 0, 0, 10, c);
        chk("addi_after_abort", 32'(c), 32'd4);

        trap_cycles = 0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 199) == 0 || trap_cycles > 25) begin
                mem_ready = 1'($urandom_range(0, 1));
                do_reset(1'b0);
                trap_cycles = 0;
            end else begin
                opcode = pick_op();
                mem_ready = ($urandom_range(0, 3) != 0);
                @(posedge clk);
                #1;
                trap_cycles = m_trap ? trap_cycles + 1 : 0;
            end
        end

        chk_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_fail);
        $finish;
    end

endmodule
